// File: rtl/ram8_16.sv
// ram8_16: 8 x 16-bit register memory (Hack RAM8) built from Nand-derived gates and sync-clear DFFs
module nand_g (
  input  logic a,
  input  logic b,
  output logic y
);
  assign y = ~(a & b);
endmodule

module not_g (
  input  logic a,
  output logic y
);
  nand_g u_n (.a(a), .b(a), .y(y));
endmodule

module and_g (
  input  logic a,
  input  logic b,
  output logic y
);
  logic n;
  nand_g u_n (.a(a), .b(b), .y(n));
  not_g  u_i (.a(n), .y(y));
endmodule

module or_g (
  input  logic a,
  input  logic b,
  output logic y
);
  logic na, nb;
  not_g  u_a (.a(a), .y(na));
  not_g  u_b (.a(b), .y(nb));
  nand_g u_n (.a(na), .b(nb), .y(y));
endmodule

module mux_g (
  input  logic a,
  input  logic b,
  input  logic sel,
  output logic y
);
  logic ns, t0, t1;
  not_g u_s  (.a(sel), .y(ns));
  and_g u_a  (.a(a), .b(ns), .y(t0));
  and_g u_b  (.a(b), .b(sel), .y(t1));
  or_g  u_o  (.a(t0), .b(t1), .y(y));
endmodule

module dmux_g (
  input  logic in,
  input  logic sel,
  output logic a,
  output logic b
);
  logic ns;
  not_g u_s (.a(sel), .y(ns));
  and_g u_a (.a(in), .b(ns), .y(a));
  and_g u_b (.a(in), .b(sel), .y(b));
endmodule

module mux16 (
  input  logic [15:0] a,
  input  logic [15:0] b,
  input  logic        sel,
  output logic [15:0] y
);
  for (genvar i = 0; i < 16; i++) begin : g_bit
    mux_g u_m (.a(a[i]), .b(b[i]), .sel(sel), .y(y[i]));
  end
endmodule

module mux4way16 (
  input  logic [3:0][15:0] d,
  input  logic [1:0]       sel,
  output logic [15:0]      y
);
  logic [15:0] lo, hi;
  mux16 u_lo (.a(d[0]), .b(d[1]), .sel(sel[0]), .y(lo));
  mux16 u_hi (.a(d[2]), .b(d[3]), .sel(sel[0]), .y(hi));
  mux16 u_y  (.a(lo), .b(hi), .sel(sel[1]), .y(y));
endmodule

module mux8way16 (
  input  logic [7:0][15:0] d,
  input  logic [2:0]       sel,
  output logic [15:0]      y
);
  logic [15:0] lo, hi;
  mux4way16 u_lo (.d(d[3:0]), .sel(sel[1:0]), .y(lo));
  mux4way16 u_hi (.d(d[7:4]), .sel(sel[1:0]), .y(hi));
  mux16     u_y  (.a(lo), .b(hi), .sel(sel[2]), .y(y));
endmodule

module dmux4way (
  input  logic       in,
  input  logic [1:0] sel,
  output logic [3:0] y
);
  logic lo, hi;
  dmux_g u_top (.in(in), .sel(sel[1]), .a(lo), .b(hi));
  dmux_g u_lo  (.in(lo), .sel(sel[0]), .a(y[0]), .b(y[1]));
  dmux_g u_hi  (.in(hi), .sel(sel[0]), .a(y[2]), .b(y[3]));
endmodule

module dmux8way (
  input  logic       in,
  input  logic [2:0] sel,
  output logic [7:0] y
);
  logic lo, hi;
  dmux_g   u_top (.in(in), .sel(sel[2]), .a(lo), .b(hi));
  dmux4way u_lo  (.in(lo), .sel(sel[1:0]), .y(y[3:0]));
  dmux4way u_hi  (.in(hi), .sel(sel[1:0]), .y(y[7:4]));
endmodule

module dff_clr (
  input  logic clk,
  input  logic clr,
  input  logic d,
  output logic q
);
  logic q_q, q_d;
  always_comb q_d = clr ? 1'b0 : d;
  always_ff @(posedge clk) q_q <= q_d;
  assign q = q_q;
endmodule

module reg16 (
  input  logic        clk,
  input  logic        clr,
  input  logic [15:0] d,
  output logic [15:0] q
);
  for (genvar i = 0; i < 16; i++) begin : g_bit
    dff_clr u_ff (.clk(clk), .clr(clr), .d(d[i]), .q(q[i]));
  end
endmodule

module ram8_16 #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 8
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic [WIDTH-1:0]         in,
  input  logic                     load,
  input  logic [$clog2(DEPTH)-1:0] address,
  output logic [WIDTH-1:0]         out
);
  logic [DEPTH-1:0]            en;
  logic [DEPTH-1:0][WIDTH-1:0] word, nxt;
  dmux8way u_en (.in(load), .sel(address), .y(en));
  // each word recirculates itself unless its one-hot enable picks in
  for (genvar i = 0; i < DEPTH; i++) begin : g_word
    mux16 u_nxt (.a(word[i]), .b(in), .sel(en[i]), .y(nxt[i]));
    reg16 u_reg (.clk(clock), .clr(reset), .d(nxt[i]), .q(word[i]));
  end
  mux8way16 u_rd (.d(word), .sel(address), .y(out));
endmodule

// File: doc/ram8_16.md
Name: ram8_16

Overview:
- 8-word x 16-bit synchronous register memory, equivalent to the Hack RAM8 chip.
- Sits directly downstream of the combinational gate library and is built from it:
  - DMux8Way steers load to one word.
  - Mux8Way16 selects the read word.
  - Mux16 forms each word's next-state path.
- Storage is 128 flip-flop bits.
- Serves as the building block for RAM64 and higher memories, and for the register/PC stage.

Parameters:
- WIDTH, 16, word width. Fixed at 16 for Hack compatibility; other values are unsupported.
- DEPTH, 8, number of words. Fixed; address width is 3.

Ports:
- clock  input  1  single clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-high; clears all words on a rising edge while high.
- in  input  16  write data.
- load  input  1  write enable for the word selected by address.
- address  input  3  word select, used for both the write and the read.
- out  output  16  contents of word[address]; combinational read.

Behaviour:
- State: word[0..7], 16 bits each.
- Reset:
  - On a rising edge with reset=1, all eight words become 0x0000.
  - reset has priority over load: no write occurs on that edge.
  - out therefore reads 0x0000 for every address from the next cycle.
  - Before the first reset, word contents are X; the bench must not check them.
- Write:
  - On a rising edge with reset=0 and load=1, word[address] <= in.
  - All other words hold.
  - Only one word is written per edge. Each per-word enable is the DMux8Way output for load and address.
- Hold: on a rising edge with reset=0 and load=0, every word holds. Each word's next state is Mux16(word, in, enable_i).
- Read:
  - out = word[address], combinational through Mux8Way16.
  - Read latency is 0 cycles for stored data.
  - A write becomes visible on out immediately after the rising edge that performs it.
  - There is no write-through within the same cycle: before the edge, out shows the old value even when load=1 and address matches.
- Simultaneous read/write at the same address: out shows the old value until the edge and the new value after it.
- Address change: out follows address combinationally within the same cycle. No state effect.
- Reset asserted mid-sequence: reset clears regardless of pending load, address or in values.
- Back-to-back writes:
  - Writes to the same address on consecutive edges: the last write wins.
  - Writes to different addresses on consecutive edges: both persist.
- X-propagation: in, load and address must be known whenever reset=0 and a rising edge occurs. Otherwise the result is undefined.
- Implementation:
  - Per-bit storage is a D flip-flop with synchronous clear.
  - Gate-level composition uses the existing Nand-derived primitives.
  - No behavioural arrays.

Test Plan:
- Reset clear: write 0xFFFF to all 8 words, then reset=1 for 1 edge -> out=0x0000 at address 0..7.
- Write/readback: after reset, write word[i] = 0x1111*i+1 for i=0..7 on successive edges -> reading address i returns 0x0001, 0x1112, ..., 0x7778.
- No write-through: word[3]=0x00AA; set in=0x5555, load=1, address=3 -> before the edge out=0x00AA; after the edge out=0x5555; word[2] and word[4] unchanged.
- Hold with load=0: set in=0xBEEF, load=0, sweep address 0..7 over 8 edges -> all words unchanged.
- Reset priority: reset=1, load=1, address=5, in=0x1234 on the same edge -> word[5]=0x0000 and all words 0x0000.
- Same-address overwrite: write address 6 with 0x0F0F, then 0xF0F0 on the next edge -> out@6=0xF0F0; word[7]=0x0000 untouched.
